// File: rtl/sh_pkg.sv
// Shared types and the word-shift helper for the serial shift-register blocks.
// The helper works on a fixed maximum width, so callers must have W <= SH_MAX_W.
package sh_pkg;

  typedef enum logic {IDLE, SHIFT} sh_state_t;

  localparam int SH_MAX_W = 64;
  localparam int SH_IDX_W = $clog2(SH_MAX_W);
  localparam logic [SH_MAX_W:0] SH_ONE = 1;

  // Shift the low w bits of q one place, inserting fill at the vacated end.
  // dir = 1 shifts toward the MSB (fill enters at bit 0).
  // Bits at w and above come back as zero.
  function automatic logic [SH_MAX_W-1:0] next_shift(
    input logic [SH_MAX_W-1:0] q,
    input int                  w,
    input logic                dir,
    input logic                fill
  );
    logic [SH_MAX_W-1:0] r;
    logic [SH_MAX_W:0]   m;
    m = (SH_ONE << w) - SH_ONE;
    if (dir) begin
      r = {q[SH_MAX_W-2:0], fill};
    end else begin
      r = q >> 1;
      r[SH_IDX_W'(w - 1)] = fill;
    end
    return r & m[SH_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sh_reg_frame_if.sv
// Word-load handshake and serial-side signals of the frame shift register.
interface sh_reg_frame_if #(parameter int W = 8);
  logic         ld_valid;
  logic         ld_ready;
  logic [W-1:0] d;
  logic         msb_first;
  logic         rot;
  logic         shen;
  logic         s_in;
  logic         abort;
  logic         s_out;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  modport master (
    output ld_valid, d, msb_first, rot, shen, s_in, abort,
    input  ld_ready, s_out, q, busy, done
  );

  modport slave (
    input  ld_valid, d, msb_first, rot, shen, s_in, abort,
    output ld_ready, s_out, q, busy, done
  );
endinterface

// File: rtl/sh_bitcnt.sv
// Loadable down-counter: loads N, counts down on dec, tc flags the last count.
module sh_bitcnt #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic dec,
  output logic tc
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (load)    cnt <= CW'(N);
    else if (dec)     cnt <= cnt - CW'(1);
  end

  assign tc = (cnt == CW'(1));
endmodule

// File: rtl/sh_reg_frame.sv
// W-bit frame shift register: handshake load, W shift ticks per frame, done pulse.
module sh_reg_frame
  import sh_pkg::*;
#(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst,
  sh_reg_frame_if.slave bus
);
  sh_state_t    state, state_nxt;
  logic [W-1:0] q;
  logic         dir_r, rot_r, done_r;
  logic         load, shift, clear, last, fill, s_out;

  sh_bitcnt #(.N(W)) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .clear(clear),
    .dec  (shift),
    .tc   (last)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ld_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // abort beats a pending final shift, so no done pulse can follow it
        if (bus.abort) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (bus.shen) begin
          shift = 1'b1;
          if (last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign s_out = dir_r ? q[W-1] : q[0];
  assign fill  = rot_r ? s_out : bus.s_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      dir_r  <= 1'b1;
      rot_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= shift & last;
      if (load) begin
        q     <= bus.d;
        dir_r <= bus.msb_first;
        rot_r <= bus.rot;
      end else if (shift) begin
        q <= W'(next_shift(SH_MAX_W'(q), W, dir_r, fill));
      end
    end
  end

  assign bus.ld_ready = (state == IDLE);
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_r;
  assign bus.q        = q;
  assign bus.s_out    = s_out;
endmodule

// File: tb/tb_sh_reg_frame.sv
// Directed bench for sh_reg_frame: frame-level reference model plus literal checks.
module tb_sh_reg_frame;
  localparam int W = 8;

  logic clk, rst;
  int   nvec = 0, nerr = 0;
  bit   started = 0;

  sh_reg_frame_if #(.W(W)) bus ();

  sh_reg_frame #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: remaining ticks in the frame and the word as the serial rules dictate.
  logic [W-1:0] mq;
  int           mleft;
  bit           mbusy, mdir, mrot, mdone;

  always @(posedge clk) begin
    logic ob, fb;
    mdone = 0;
    if (rst) begin
      mq = '0; mleft = 0; mbusy = 0; mdir = 1; mrot = 0;
    end else if (!mbusy) begin
      if (bus.ld_valid) begin
        mq = bus.d; mleft = W; mbusy = 1; mdir = bus.msb_first; mrot = bus.rot;
      end
    end else if (bus.abort) begin
      mbusy = 0; mleft = 0;
    end else if (bus.shen) begin
      ob = mdir ? mq[W-1] : mq[0];
      fb = mrot ? ob : bus.s_in;
      mq = mdir ? {mq[W-2:0], fb} : {fb, mq[W-1:1]};
      mleft = mleft - 1;
      if (mleft == 0) begin
        mbusy = 0; mdone = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [W+3:0] act, exp;
      act = {bus.q, bus.s_out, bus.ld_ready, bus.busy, bus.done};
      exp = {mq, (mdir ? mq[W-1] : mq[0]), !mbusy, mbusy, mdone};
      nvec++;
      if (act !== exp) begin
        nerr++;
        $display("FAIL model t=%0t {q,s_out,ld_ready,busy,done}: got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] w1, w2;
    rst = 1;
    bus.ld_valid = 0; bus.d = '0; bus.msb_first = 1; bus.rot = 0;
    bus.shen = 0; bus.s_in = 0; bus.abort = 0;
    cyc(); cyc();
    rst = 0;
    started = 1;
    chk("reset q", bus.q, 0);
    chk("reset ld_ready", bus.ld_ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset s_out", bus.s_out, 0);
    chk("reset done", bus.done, 0);

    // MSB first, s_in refill with 3C
    w1 = 8'hA5; w2 = 8'h3C;
    bus.d = w1; bus.msb_first = 1; bus.rot = 0; bus.ld_valid = 1; bus.shen = 1;
    cyc();
    bus.ld_valid = 0;
    chk("t1 q after load", bus.q, 8'hA5);
    for (int i = 0; i < W; i++) begin
      bus.s_in = w2[W-1-i];
      chk("t1 s_out bit", bus.s_out, w1[W-1-i]);
      chk("t1 no early done", bus.done, 0);
      cyc();
    end
    chk("t1 done", bus.done, 1);
    chk("t1 q", bus.q, 8'h3C);
    chk("t1 ld_ready", bus.ld_ready, 1);
    bus.shen = 0;
    cyc();
    chk("t1 done one cycle", bus.done, 0);

    // LSB first rotate, tick every third cycle; direction/rot flipped mid-frame
    w1 = 8'h81;
    bus.d = w1; bus.msb_first = 0; bus.rot = 1; bus.ld_valid = 1;
    cyc();
    bus.ld_valid = 0;
    for (int i = 0; i < W; i++) begin
      if (i == 3) begin
        bus.msb_first = 1; bus.rot = 0; bus.s_in = 0;
      end
      bus.shen = 0;
      cyc(); cyc();
      chk("t2 s_out bit", bus.s_out, w1[i]);
      chk("t2 busy", bus.busy, 1);
      bus.shen = 1;
      cyc();
    end
    bus.shen = 0;
    chk("t2 done", bus.done, 1);
    chk("t2 q", bus.q, 8'h81);

    // abort after 3 shifts
    bus.d = 8'hFF; bus.msb_first = 1; bus.rot = 0; bus.s_in = 0; bus.ld_valid = 1;
    cyc();
    bus.ld_valid = 0; bus.shen = 1;
    cyc(); cyc(); cyc();
    bus.abort = 1;
    cyc();
    bus.abort = 0; bus.shen = 0;
    chk("t3 q frozen", bus.q, 8'hF8);
    chk("t3 ld_ready", bus.ld_ready, 1);
    chk("t3 no done", bus.done, 0);
    cyc();
    chk("t3 still no done", bus.done, 0);

    // ld_valid held high, d changing every cycle
    bus.shen = 1; bus.s_in = 1; bus.ld_valid = 1; bus.d = 8'h11;
    cyc();
    chk("t4 first load", bus.q, 8'h11);
    for (int i = 0; i < W; i++) begin
      bus.d = 8'(8'h20 + i);
      cyc();
    end
    chk("t4 done", bus.done, 1);
    chk("t4 ld_ready in done", bus.ld_ready, 1);
    bus.d = 8'h5A;
    cyc();
    chk("t4 reload in done cycle", bus.q, 8'h5A);
    chk("t4 busy", bus.busy, 1);
    bus.ld_valid = 0;
    for (int i = 0; i < W; i++) cyc();
    chk("t4 second done", bus.done, 1);
    chk("t4 second q", bus.q, 8'hFF);

    // reset on the final shift edge
    bus.d = 8'hC3; bus.s_in = 0; bus.ld_valid = 1;
    cyc();
    bus.ld_valid = 0;
    for (int i = 0; i < W - 1; i++) cyc();
    rst = 1;
    cyc();
    rst = 0; bus.shen = 0;
    chk("t5 rst done", bus.done, 0);
    chk("t5 rst q", bus.q, 0);
    chk("t5 rst ld_ready", bus.ld_ready, 1);

    // abort and ld_valid together in SHIFT
    bus.d = 8'h12; bus.ld_valid = 1;
    cyc();
    bus.d = 8'h34; bus.abort = 1;
    cyc();
    bus.abort = 0; bus.ld_valid = 0;
    chk("t5 abort wins q", bus.q, 8'h12);
    chk("t5 abort idle", bus.busy, 0);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
